// File: rtl/riscv_multicycle_ctrl.sv
// rtl/riscv_multicycle_ctrl.sv - multicycle RV32I sequencing FSM with memory-ready stalls
module riscv_multicycle_ctrl #(
    parameter bit MEM_WAIT_EN     = 1'b1,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] imm_src,
    output logic [3:0] alu_control,
    output logic [3:0] state,
    output logic       trap
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10,
        S_LUI      = 4'd11,
        S_AUIPC    = 4'd12,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b1101;
    localparam logic [3:0] ALU_SLL   = 4'b0110;
    localparam logic [3:0] ALU_SRL   = 4'b0111;
    localparam logic [3:0] ALU_SRA   = 4'b1111;
    localparam logic [3:0] ALU_LUI   = 4'b1110;
    localparam logic [3:0] ALU_AUIPC = 4'b1001;

    state_t     state_q, state_d;
    logic       mem_rdy;
    logic [3:0] alu_dec;
    logic       pc_write_c, ir_write_c, mem_write_c, reg_write_c;

    assign mem_rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // funct7b5 only selects sub for R-type; for shifts it selects sra in both formats
    always_comb begin
        alu_dec = ALU_ADD;
        case (funct3)
            3'b000: alu_dec = ((state_q == S_EXECR) && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001: alu_dec = ALU_SLL;
            3'b010: alu_dec = ALU_SLT;
            3'b011: alu_dec = ALU_SLTU;
            3'b100: alu_dec = ALU_XOR;
            3'b101: alu_dec = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110: alu_dec = ALU_OR;
            3'b111: alu_dec = ALU_AND;
            default: alu_dec = ALU_ADD;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_write_c  = 1'b0;
        ir_write_c  = 1'b0;
        mem_write_c = 1'b0;
        reg_write_c = 1'b0;
        adr_src     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        imm_src     = 3'b000;
        alu_control = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write_c = mem_rdy;
                pc_write_c = mem_rdy;
                if (mem_rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = (op == OP_JAL) ? 3'b011 : 3'b010;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_JAL:            state_d = S_JAL;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           state_d = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = (op == OP_STORE) ? 3'b001 : 3'b000;
                state_d   = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_rdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                mem_write_c = 1'b1;
                if (mem_rdy) state_d = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = alu_dec;
                state_d     = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_dec;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_write_c = 1'b1;
                state_d    = S_ALUWB;
            end
            S_BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                pc_write_c  = branch_taken;
                state_d     = S_FETCH;
            end
            S_LUI: begin
                alu_src_b   = 2'b01;
                imm_src     = 3'b100;
                alu_control = ALU_LUI;
                state_d     = S_ALUWB;
            end
            S_AUIPC: begin
                alu_src_a   = 2'b01;
                alu_src_b   = 2'b01;
                imm_src     = 3'b100;
                alu_control = ALU_AUIPC;
                state_d     = S_ALUWB;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    // FETCH would otherwise raise ir_write/pc_write from mem_ready while reset is held
    assign pc_write  = pc_write_c  & ~reset;
    assign ir_write  = ir_write_c  & ~reset;
    assign mem_write = mem_write_c & ~reset;
    assign reg_write = reg_write_c & ~reset;
    assign state     = state_q;
    assign trap      = (state_q == S_TRAP);

endmodule
